// File: rtl/ab_input_conditioner.sv
// -----------------------------------------------------------------------------
// ab_input_conditioner
//   Front end for the A/B inputs of the lab sequential circuit. Each raw switch
//   level is synchronised, then debounced by a small per-channel FSM. The stage
//   presents clean levels plus one-cycle change pulses. A valid flag rises once
//   the synchroniser/debounce pipeline has been filled after reset.
//
// Ports
//   clk    in  1  single clock, all state updates on posedge
//   rst_n  in  1  asynchronous active-low reset
//   sw_a   in  1  raw switch A (asynchronous, may bounce)
//   sw_b   in  1  raw switch B (asynchronous, may bounce)
//   a      out 1  debounced level of sw_a
//   b      out 1  debounced level of sw_b
//   a_tgl  out 1  one-cycle pulse in the first cycle a shows a new value
//   b_tgl  out 1  one-cycle pulse in the first cycle b shows a new value
//   valid  out 1  high once the warm-up period after reset has elapsed
// -----------------------------------------------------------------------------
module ab_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_a,
    input  logic sw_b,
    output logic a,
    output logic b,
    output logic a_tgl,
    output logic b_tgl,
    output logic valid
);

    localparam int WARM_CYCLES = SYNC_STAGES + DEBOUNCE_CYCLES;

    // Parameter sanity checks, evaluated at elaboration.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("ab_input_conditioner: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
        $error("ab_input_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end
    if (((2 ** CNT_W) - 1) < WARM_CYCLES) begin : g_bad_cnt_w
        $error("ab_input_conditioner: CNT_W too small for SYNC_STAGES+DEBOUNCE_CYCLES");
    end

    typedef enum logic [0:0] {
        ST_STABLE   = 1'b0,
        ST_CHANGING = 1'b1
    } deb_state_t;

    logic [1:0] raw_s;
    logic [1:0] lvl_s;
    logic [1:0] tgl_s;

    assign raw_s = {sw_b, sw_a};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_r;
        logic                   synced_s;
        deb_state_t             state_r;
        logic [CNT_W-1:0]       cnt_r;
        logic                   lvl_r;
        logic                   tgl_r;

        // Synchroniser chain; only its last stage is seen by the debouncer.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_r <= {SYNC_STAGES{1'b0}};
            end else begin
                sync_r <= {sync_r[SYNC_STAGES-2:0], raw_s[ch]};
            end
        end

        assign synced_s = sync_r[SYNC_STAGES-1];

        // Debounce FSM: a new level is accepted only after DEBOUNCE_CYCLES
        // consecutive disagreeing edges; any agreement restarts the count.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_r <= ST_STABLE;
                cnt_r   <= {CNT_W{1'b0}};
                lvl_r   <= 1'b0;
                tgl_r   <= 1'b0;
            end else begin
                tgl_r <= 1'b0;
                case (state_r)
                    ST_STABLE: begin
                        if (synced_s != lvl_r) begin
                            state_r <= ST_CHANGING;
                            cnt_r   <= CNT_W'(1);
                        end else begin
                            cnt_r   <= {CNT_W{1'b0}};
                        end
                    end
                    ST_CHANGING: begin
                        if (synced_s == lvl_r) begin
                            // Bounced back before acceptance: drop the count.
                            state_r <= ST_STABLE;
                            cnt_r   <= {CNT_W{1'b0}};
                        end else if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                            lvl_r   <= synced_s;
                            tgl_r   <= 1'b1;
                            cnt_r   <= {CNT_W{1'b0}};
                            state_r <= ST_STABLE;
                        end else begin
                            cnt_r   <= cnt_r + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_r <= ST_STABLE;
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                endcase
            end
        end

        assign lvl_s[ch] = lvl_r;
        assign tgl_s[ch] = tgl_r;
    end

    assign a     = lvl_s[0];
    assign b     = lvl_s[1];
    assign a_tgl = tgl_s[0];
    assign b_tgl = tgl_s[1];

    logic [CNT_W-1:0] warm_cnt_r;
    logic             valid_r;

    // Warm-up counter: saturates at WARM_CYCLES; valid rises on that edge
    // and holds until the next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt_r <= {CNT_W{1'b0}};
            valid_r    <= 1'b0;
        end else begin
            if (warm_cnt_r != CNT_W'(WARM_CYCLES)) begin
                warm_cnt_r <= warm_cnt_r + CNT_W'(1);
            end else begin
                warm_cnt_r <= warm_cnt_r;
            end
            if (warm_cnt_r == CNT_W'(WARM_CYCLES - 1)) begin
                valid_r <= 1'b1;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign valid = valid_r;

endmodule

// File: tb/tb_ab_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_ab_input_conditioner
//   Directed bench. dut uses SYNC_STAGES=2, DEBOUNCE_CYCLES=4; dut16 uses the
//   default DEBOUNCE_CYCLES=16. Inputs are driven on the falling edge so the
//   next rising edge is the first to sample them; outputs are checked on the
//   falling edge.
// -----------------------------------------------------------------------------
module tb_ab_input_conditioner;

    logic clk;
    logic rst_n;
    logic sw_a, sw_b;
    logic a, b, a_tgl, b_tgl, valid;
    logic sw16_a, sw16_b;
    logic a16, b16, a16_tgl, b16_tgl, valid16;

    int checks;
    int failures;
    int a_tgl_seen;

    ab_input_conditioner #(
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sw_a(sw_a), .sw_b(sw_b),
        .a(a), .b(b), .a_tgl(a_tgl), .b_tgl(b_tgl), .valid(valid)
    );

    ab_input_conditioner dut16 (
        .clk(clk), .rst_n(rst_n), .sw_a(sw16_a), .sw_b(sw16_b),
        .a(a16), .b(b16), .a_tgl(a16_tgl), .b_tgl(b16_tgl), .valid(valid16)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge, then settle on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (a_tgl) a_tgl_seen++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        checks = 0; failures = 0; a_tgl_seen = 0;
        rst_n = 1'b0; sw_a = 1'b0; sw_b = 1'b0; sw16_a = 1'b0; sw16_b = 1'b0;
        steps(3);

        // 1: reset state, warm-up, valid holds
        check_eq("rst_a", a, 1'b0);
        check_eq("rst_b", b, 1'b0);
        check_eq("rst_tgl", {a_tgl, b_tgl}, 2'b00);
        check_eq("rst_valid", valid, 1'b0);
        rst_n = 1'b1;
        steps(5);
        check_eq("valid_edge5", valid, 1'b0);
        step();
        check_eq("valid_edge6", valid, 1'b1);
        for (int i = 0; i < 50; i++) begin
            step();
            check_eq("valid_hold", valid, 1'b1);
            check_eq("idle_ab", {a, b, a_tgl, b_tgl}, 4'b0000);
        end

        // 2: clean rising step on A
        sw_a = 1'b1;
        steps(5);
        check_eq("step_a_early", a, 1'b0);
        check_eq("step_tgl_early", a_tgl, 1'b0);
        step();
        check_eq("step_a_edge6", a, 1'b1);
        check_eq("step_tgl_edge6", a_tgl, 1'b1);
        step();
        check_eq("step_tgl_after", a_tgl, 1'b0);
        check_eq("step_a_hold", a, 1'b1);
        sw_a = 1'b0;
        steps(8);
        check_eq("step_a_back0", a, 1'b0);

        // 3: short glitches are rejected, a 4-cycle pulse is accepted
        a_tgl_seen = 0;
        for (int p = 0; p < 3; p++) begin
            sw_a = 1'b1; step();
            sw_a = 1'b0; steps(4);
        end
        sw_a = 1'b1; steps(3);
        sw_a = 1'b0; steps(8);
        check_eq("glitch_a", a, 1'b0);
        check_eq("glitch_tgl_cnt", a_tgl_seen, 0);
        sw_a = 1'b1; steps(4);
        sw_a = 1'b0; steps(2);
        check_eq("pulse4_a", a, 1'b1);
        check_eq("pulse4_tgl", a_tgl, 1'b1);
        steps(8);
        check_eq("pulse4_a_back0", a, 1'b0);

        // 4: simultaneous change on both channels
        sw_a = 1'b1; sw_b = 1'b1;
        steps(5);
        check_eq("both_tgl_early", {a_tgl, b_tgl}, 2'b00);
        step();
        check_eq("both_tgl", {a_tgl, b_tgl}, 2'b11);
        check_eq("both_lvl", {a, b}, 2'b11);
        sw_a = 1'b0; sw_b = 1'b0;
        steps(8);
        check_eq("both_back0", {a, b}, 2'b00);

        // 5: reset in the middle of a B count
        sw_b = 1'b1;
        steps(4);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_b", b, 1'b0);
        check_eq("midrst_valid", valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        steps(5);
        check_eq("rel_b_early", b, 1'b0);
        check_eq("rel_valid_early", valid, 1'b0);
        step();
        check_eq("rel_b_edge6", b, 1'b1);
        check_eq("rel_btgl_edge6", b_tgl, 1'b1);
        check_eq("rel_valid_edge6", valid, 1'b1);

        // 6: DEBOUNCE_CYCLES=16 instance, rising then falling
        steps(20);
        check_eq("d16_valid", valid16, 1'b1);
        sw16_a = 1'b1;
        steps(17);
        check_eq("d16_rise_early", a16, 1'b0);
        step();
        check_eq("d16_rise_edge18", a16, 1'b1);
        check_eq("d16_rise_tgl", a16_tgl, 1'b1);
        step();
        check_eq("d16_tgl_after", a16_tgl, 1'b0);
        sw16_a = 1'b0;
        steps(17);
        check_eq("d16_fall_early", a16, 1'b1);
        step();
        check_eq("d16_fall_edge18", a16, 1'b0);
        check_eq("d16_b_idle", {b16, b16_tgl}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
